// File: rtl/fft_acc_ram_reader.sv
// fft_acc_ram_reader: drains a block of on-chip RAM words into an Avalon-ST packet.
// Define FFT_ACC_RAM_READER_BITREV_EN for bit-reversed (natural-order FFT) addressing.
module fft_acc_ram_reader #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int FFT_LOG2N  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_chipselect,
    output logic              m_write,
    output logic [3:0]        m_byteenable,
    output logic [DATA_W-1:0] m_writedata,
    output logic              m_clken,
    input  logic [DATA_W-1:0] m_readdata,
    output logic [DATA_W-1:0] src_data,
    output logic              src_valid,
    input  logic              src_ready,
    output logic              src_sop,
    output logic              src_eop
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              cs_q, cs_d;
    logic              cs_sop_q, cs_sop_d;
    logic              cs_eop_q, cs_eop_d;
    logic              rv_q, rv_sop_q, rv_eop_q;
    logic              done_q, done_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W+1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W+1:0] head;
    logic [ADDR_W-1:0] offset;
    logic              push, pop, credit;

    always_comb begin
        offset = '0;
`ifdef FFT_ACC_RAM_READER_BITREV_EN
        for (int b = 0; b < FFT_LOG2N; b++) offset[FFT_LOG2N-1-b] = idx_q[b];
`else
        offset = idx_q[ADDR_W-1:0];
`endif
    end

    assign head      = mem_q[rd_ptr_q];
    assign src_valid = (cnt_q != '0);
    assign src_data  = src_valid ? head[DATA_W+1:2] : '0;
    assign src_sop   = src_valid & head[1];
    assign src_eop   = src_valid & head[0];
    assign push      = rv_q;
    assign pop       = src_valid & src_ready;

    // Both the strobe on the bus and the word returning this cycle still need a slot.
    assign credit = (int'(cnt_q) + int'(cs_q) + int'(rv_q)) < FIFO_DEPTH;

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        len_d    = len_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        cs_d     = 1'b0;
        cs_sop_d = 1'b0;
        cs_eop_d = 1'b0;
        done_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start && length == '0) begin
                    done_d = 1'b1;
                end else if (start) begin
                    base_d   = base_addr;
                    len_d    = length;
                    cs_d     = 1'b1;
                    addr_d   = base_addr;
                    cs_sop_d = 1'b1;
                    cs_eop_d = (length == (ADDR_W+1)'(1));
                    idx_d    = (ADDR_W+1)'(1);
                    state_d  = cs_eop_d ? S_DRAIN : S_READ;
                end
            end
            S_READ: begin
                if (credit) begin
                    cs_d     = 1'b1;
                    addr_d   = base_q + offset;
                    cs_eop_d = (idx_q == len_q - (ADDR_W+1)'(1));
                    idx_d    = idx_q + (ADDR_W+1)'(1);
                    if (idx_d == len_q) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && head[0]) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop) cnt_d = cnt_q + CNT_W'(1);
        else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            addr_q   <= '0;
            cs_q     <= 1'b0;
            cs_sop_q <= 1'b0;
            cs_eop_q <= 1'b0;
            rv_q     <= 1'b0;
            rv_sop_q <= 1'b0;
            rv_eop_q <= 1'b0;
            done_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            addr_q   <= addr_d;
            cs_q     <= cs_d;
            cs_sop_q <= cs_sop_d;
            cs_eop_q <= cs_eop_d;
            rv_q     <= cs_q;
            rv_sop_q <= cs_sop_q;
            rv_eop_q <= cs_eop_q;
            done_q   <= done_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {m_readdata, rv_sop_q, rv_eop_q};
    end

    assign busy         = (state_q != S_IDLE);
    assign done         = done_q;
    assign m_address    = addr_q;
    assign m_chipselect = cs_q;
    assign m_write      = 1'b0;
    assign m_byteenable = 4'hF;
    assign m_writedata  = '0;
    assign m_clken      = 1'b1;
endmodule

// File: tb/tb_fft_acc_ram_reader.sv
// tb_fft_acc_ram_reader: table of transfers plus random ones, checked cycle by
// cycle against a queue-based packet model and a FIFO occupancy model.
`timescale 1ns/1ps
module tb_fft_acc_ram_reader;
    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
`ifdef FFT_ACC_RAM_READER_BITREV_EN
    localparam int LOG2N = 3;
`else
    localparam int LOG2N = 10;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic          busy, done;
    logic [AW-1:0] m_address;
    logic          m_chipselect, m_write, m_clken;
    logic [3:0]    m_byteenable;
    logic [DW-1:0] m_writedata, m_readdata;
    logic [DW-1:0] src_data;
    logic          src_valid, src_sop, src_eop;
    logic          src_ready = 1'b0;

    always #5 clk = ~clk;

    fft_acc_ram_reader #(
        .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .FFT_LOG2N(LOG2N)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .base_addr(base_addr), .length(length),
        .busy(busy), .done(done),
        .m_address(m_address), .m_chipselect(m_chipselect),
        .m_write(m_write), .m_byteenable(m_byteenable),
        .m_writedata(m_writedata), .m_clken(m_clken),
        .m_readdata(m_readdata),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .src_sop(src_sop), .src_eop(src_eop)
    );

    logic [DW-1:0] ram [1024];
    logic [DW-1:0] rdata_q = '0;
    always @(posedge clk) if (m_chipselect) rdata_q <= ram[m_address];
    assign m_readdata = rdata_q;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_addr(input int base, input int i);
        int off;
        int v;
`ifdef FFT_ACC_RAM_READER_BITREV_EN
        v   = i % (1 << LOG2N);
        off = 0;
        repeat (LOG2N) begin
            off = off * 2 + v % 2;
            v   = v / 2;
        end
`else
        v   = 0;
        off = i + v;
`endif
        return (base + off) % 1024;
    endfunction

    typedef struct {
        int base;
        int len;
        int mode;
        int exp_done;
        int poke;
        int rst_after;
    } vec_t;

    vec_t vecs[$];

    task automatic run_xfer(input vec_t v);
        logic [DW-1:0] exp_q[$];
        int  issued, got, occ, cs_h1, cs_h2, pop_prev, exp_done_n, dut_done_n, budget;
        bit  rdy, hs, finished;
        for (int i = 0; i < v.len; i++) exp_q.push_back(ram[ref_addr(v.base, i)]);
        issued = 0; got = 0; occ = 0; cs_h1 = 0; cs_h2 = 0; pop_prev = 0;
        exp_done_n = (v.len == 0) ? 1 : -1;
        dut_done_n = -1;
        finished = 1'b0;
        budget = 10 * v.len + 40;
        @(negedge clk);
        start = 1'b1;
        base_addr = v.base[AW-1:0];
        length = v.len[AW:0];
        src_ready = 1'b0;
        @(posedge clk);
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            start = 1'b0;
            occ = occ + cs_h2 - pop_prev;
            check("src_valid", src_valid, occ != 0);
            check("fifo_le_depth", occ <= DEPTH, 1'b1);
            check("busy", busy, (v.len != 0) && (exp_done_n < 0 || n < exp_done_n));
            check("done", done, n == exp_done_n);
            if (done && dut_done_n < 0) dut_done_n = n;
            if (n == 1) check("first_cs", m_chipselect, v.len != 0);
            if (n == 1 && v.len != 0) check("first_addr", m_address, v.base % 1024);
            if (m_chipselect) begin
                check("cs_count", issued < v.len, 1'b1);
                if (issued < v.len) check("m_address", m_address, ref_addr(v.base, issued));
                issued++;
            end
            if (n == exp_done_n) begin
                check("issued_total", issued, v.len);
                if (v.exp_done > 0) check("done_cycle", dut_done_n, v.exp_done);
                finished = 1'b1;
                break;
            end
            if (v.rst_after > 0 && got == v.rst_after) begin
                reset = 1'b1;
                src_ready = 1'b0;
                @(negedge clk);
                reset = 1'b0;
                check("rst_valid", src_valid, 1'b0);
                check("rst_busy", busy, 1'b0);
                check("rst_cs", m_chipselect, 1'b0);
                check("rst_done", done, 1'b0);
                check("rst_data", src_data, 0);
                check("rst_sop_eop", {src_sop, src_eop}, 2'b00);
                finished = 1'b1;
                break;
            end
            if (v.poke != 0 && n == 4) begin
                start = 1'b1;
                base_addr = AW'(v.base + 77);
                length = (AW+1)'(3);
            end
            case (v.mode)
                0:       rdy = 1'b1;
                1:       rdy = (n % 2 == 0);
                default: rdy = 1'($urandom % 2);
            endcase
            src_ready = rdy;
            hs = (occ != 0) && rdy;
            if (hs) begin
                check("src_data", src_data, (got < v.len) ? exp_q[got] : 'x);
                check("src_sop", src_sop, got == 0);
                check("src_eop", src_eop, got == v.len - 1);
                if (got == v.len - 1) exp_done_n = n + 1;
                got++;
            end
            pop_prev = hs ? 1 : 0;
            cs_h2 = cs_h1;
            cs_h1 = m_chipselect ? 1 : 0;
        end
        check("xfer_complete", finished, 1'b1);
        start = 1'b0;
        src_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 32'h1000_0000 + i;
        vecs.push_back('{base: 0,    len: 8, mode: 0, exp_done: 11, poke: 0, rst_after: 0});
        vecs.push_back('{base: 0,    len: 8, mode: 1, exp_done: -1, poke: 0, rst_after: 0});
        vecs.push_back('{base: 1022, len: 4, mode: 0, exp_done: 7,  poke: 0, rst_after: 0});
        vecs.push_back('{base: 5,    len: 0, mode: 0, exp_done: 1,  poke: 0, rst_after: 0});
        vecs.push_back('{base: 0,    len: 8, mode: 0, exp_done: 11, poke: 1, rst_after: 0});
        vecs.push_back('{base: 0,    len: 8, mode: 0, exp_done: -1, poke: 0, rst_after: 3});
        vecs.push_back('{base: 100,  len: 2, mode: 0, exp_done: 5,  poke: 0, rst_after: 0});
        vecs.push_back('{base: 1020, len: 1, mode: 0, exp_done: 4,  poke: 0, rst_after: 0});
        for (int i = 0; i < 6; i++) begin
            vecs.push_back('{base: int'($urandom % 1024), len: 1 + int'($urandom % 40),
                             mode: 2, exp_done: -1, poke: 0, rst_after: 0});
        end
        vecs.push_back('{base: int'($urandom % 1024), len: 1024, mode: 2,
                         exp_done: -1, poke: 0, rst_after: 0});

        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_cs", m_chipselect, 1'b0);
        check("reset_addr", m_address, 0);
        check("reset_valid", src_valid, 1'b0);
        check("reset_sop_eop", {src_sop, src_eop}, 2'b00);
        check("reset_data", src_data, 0);
        check("const_write", m_write, 1'b0);
        check("const_byteen", m_byteenable, 4'hF);
        check("const_wdata", m_writedata, 0);
        check("const_clken", m_clken, 1'b1);
        reset = 1'b0;
        @(negedge clk);

        for (int k = 0; k < vecs.size(); k++) run_xfer(vecs[k]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
